gaus_buffer_reader: RTL and testbench

Read-side controller for the Gaussian line/frame buffer RAM. On a start command it issues a run of sequential read addresses to the buffer's read port, absorbs the RAM's fixed read latency, and delivers the words as a valid/ready stream with backpressure to the downstream filter stage. It sits in the RAM's read-clock domain, opposite the pixel writer that fills the buffer.

---
 rtl/gaus_buffer_reader_if.sv | 34 +++
 rtl/gaus_buffer_reader.sv | 207 ++++++++++++++++++++
 tb/tb_gaus_buffer_reader.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/gaus_buffer_reader_if.sv
`default_nettype none
// ============================================================================
// Module   : gaus_buffer_reader_if
// Purpose  : Command, RAM read-port and output-stream bundle for the
//            Gaussian buffer reader. The master modport is the reader itself.
// Revision : 1.0 - initial release
// ============================================================================
interface gaus_buffer_reader_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 20
);
    logic                  start;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [ADDR_WIDTH-1:0] length;
    logic                  busy;
    logic                  done;
    logic [ADDR_WIDTH-1:0] read_addr;
    logic [DATA_WIDTH-1:0] ram_q;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_last;
    logic                  m_ready;

    modport master (
        input  start, base_addr, length, ram_q, m_ready,
        output busy, done, read_addr, m_data, m_valid, m_last
    );

    modport slave (
        output start, base_addr, length, ram_q, m_ready,
        input  busy, done, read_addr, m_data, m_valid, m_last
    );
endinterface
`default_nettype wire

// File: rtl/gaus_buffer_reader.sv
`default_nettype none
// ============================================================================
// Module   : gaus_buffer_reader
// Purpose  : Issues a sequential run of RAM read addresses, realigns the
//            fixed-latency read data with a valid tag pipeline and delivers
//            it through a credit-protected skid FIFO as a valid/ready stream.
// Revision : 1.0 - initial release
// ============================================================================
module gaus_buffer_reader #(
    parameter int DATA_WIDTH  = 64,
    parameter int ADDR_WIDTH  = 20,
    parameter int RAM_LATENCY = 3,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    gaus_buffer_reader_if.master bus
);
    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    // Tags live in the address register stage plus RAM_LATENCY shift stages.
    localparam int c_INF_W = $clog2(RAM_LATENCY + 2);
    localparam int c_OCC_W = c_CNT_W + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic                  r_done;
    logic                  w_done_next;

    logic [ADDR_WIDTH-1:0] r_base;
    logic [ADDR_WIDTH-1:0] r_length;
    logic [ADDR_WIDTH-1:0] r_issued;
    logic [ADDR_WIDTH-1:0] r_captured;
    logic [ADDR_WIDTH-1:0] r_read_addr;
    logic                  r_addr_vld;
    logic [RAM_LATENCY-1:0] r_tag;

    logic [DATA_WIDTH-1:0] r_fifo_data [FIFO_DEPTH];
    logic                  r_fifo_last [FIFO_DEPTH];
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_CNT_W-1:0]    r_fifo_cnt;

    logic                  w_nonempty;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_push_last;
    logic [c_INF_W-1:0]    w_inflight;
    logic [c_OCC_W-1:0]    w_occ;
    logic                  w_credit;
    logic                  w_start_acc;
    logic                  w_issue;
    logic [ADDR_WIDTH-1:0] w_issue_addr;
    logic [ADDR_WIDTH-1:0] w_issued_next;
    logic [ADDR_WIDTH-1:0] w_run_len;
    logic                  w_last_issue;
    logic                  w_drain_empty;

    assign w_nonempty  = (r_fifo_cnt != '0);
    assign w_pop       = w_nonempty && bus.m_ready;
    assign w_push      = r_tag[RAM_LATENCY-1];
    assign w_push_last = ((r_captured + ADDR_WIDTH'(1)) == r_length);

    // Count every read whose data has not yet reached the FIFO.
    always_comb begin
        w_inflight = c_INF_W'(r_addr_vld);
        for (int i = 0; i < RAM_LATENCY; i++) begin
            w_inflight = w_inflight + c_INF_W'(r_tag[i]);
        end
    end

    // A new read is allowed only if its word is guaranteed a FIFO slot.
    assign w_occ    = c_OCC_W'(w_inflight) + c_OCC_W'(r_fifo_cnt) - c_OCC_W'(w_pop);
    assign w_credit = (w_occ < c_OCC_W'(FIFO_DEPTH));

    // The first read is issued on the accepting edge so read_addr shows base
    // in the first busy cycle; later reads are issued from RUN under credit.
    assign w_start_acc   = (r_state == S_IDLE) && bus.start;
    assign w_issue       = (w_start_acc && (bus.length != '0)) ||
                           ((r_state == S_RUN) && w_credit);
    assign w_issue_addr  = (r_state == S_IDLE) ? bus.base_addr : (r_base + r_issued);
    assign w_issued_next = (r_state == S_IDLE) ? ADDR_WIDTH'(1) : (r_issued + ADDR_WIDTH'(1));
    assign w_run_len     = (r_state == S_IDLE) ? bus.length : r_length;
    assign w_last_issue  = w_issue && (w_issued_next == w_run_len);

    // Drain completes when nothing is in flight and the FIFO empties this cycle.
    assign w_drain_empty = (w_inflight == '0) &&
                           ((r_fifo_cnt == '0) || ((r_fifo_cnt == c_CNT_W'(1)) && w_pop));

    // State and done pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= w_done_next;
        end
    end

    // Next-state and done decode.
    always_comb begin
        w_state_next = r_state;
        w_done_next  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    if ((bus.length == '0) || w_last_issue) begin
                        w_state_next = S_DRAIN;
                    end else begin
                        w_state_next = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (w_last_issue) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_drain_empty) begin
                    w_state_next = S_IDLE;
                    w_done_next  = 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Run parameters, issue/capture counters and the read address register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_base      <= '0;
            r_length    <= '0;
            r_issued    <= '0;
            r_captured  <= '0;
            r_read_addr <= '0;
            r_addr_vld  <= 1'b0;
        end else begin
            r_addr_vld <= w_issue;
            if (w_start_acc) begin
                r_base     <= bus.base_addr;
                r_length   <= bus.length;
                r_captured <= '0;
            end else if (w_push) begin
                r_captured <= r_captured + ADDR_WIDTH'(1);
            end
            if (w_issue) begin
                r_issued    <= w_issued_next;
                r_read_addr <= w_issue_addr;
            end else if (w_start_acc) begin
                r_issued <= '0;
            end
        end
    end

    // Valid tags follow each issued address through the RAM read pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tag <= '0;
        end else begin
            r_tag <= (r_tag << 1) | RAM_LATENCY'(r_addr_vld);
        end
    end

    // Skid FIFO: captures tagged RAM words, pops on stream handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fifo_cnt <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo_data[i] <= '0;
                r_fifo_last[i] <= 1'b0;
            end
        end else begin
            if (w_push) begin
                r_fifo_data[r_wr_ptr] <= bus.ram_q;
                r_fifo_last[r_wr_ptr] <= w_push_last;
                r_wr_ptr              <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + c_CNT_W'(1);
                2'b01:   r_fifo_cnt <= r_fifo_cnt - c_CNT_W'(1);
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
        end
    end

    assign bus.m_valid   = w_nonempty;
    assign bus.m_data    = w_nonempty ? r_fifo_data[r_rd_ptr] : '0;
    assign bus.m_last    = w_nonempty && r_fifo_last[r_rd_ptr];
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.done      = r_done;
    assign bus.read_addr = r_read_addr;

endmodule
`default_nettype wire

// File: tb/tb_gaus_buffer_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_gaus_buffer_reader
// Purpose  : Scoreboard bench for gaus_buffer_reader with a latency-3 RAM
//            model and randomized runs and backpressure.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gaus_buffer_reader;
    localparam int c_DW = 64;
    localparam int c_AW = 20;

    typedef struct packed {
        logic [c_DW-1:0] d;
        logic            l;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   ready_mode = 1;
    int   t0 = 0;
    int   delivered = 0;
    logic [c_AW-1:0] run_base = '0;
    logic [c_AW-1:0] run_len  = '0;
    exp_t sb[$];
    exp_t mon_e;

    logic [c_AW-1:0] ra1 = '0;
    logic [c_AW-1:0] ra2 = '0;
    logic [c_DW-1:0] q_r = '0;

    int first_v, last_rel, done_rel, done_cnt, busy_cnt;
    logic [c_AW-1:0] ra_log [0:15];

    gaus_buffer_reader_if #(.DATA_WIDTH(c_DW), .ADDR_WIDTH(c_AW)) bus ();

    gaus_buffer_reader #(
        .DATA_WIDTH (c_DW),
        .ADDR_WIDTH (c_AW),
        .RAM_LATENCY(3),
        .FIFO_DEPTH (8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM content: a fixed function of the word address.
    function automatic logic [c_DW-1:0] ref_word(input logic [c_AW-1:0] a);
        logic [31:0] h;
        h = {12'd0, a} * 32'h9E3779B1;
        return {h, 12'h5A5, a};
    endfunction

    // Buffer RAM read port: address to q sampled takes three cycles.
    always @(posedge clk) begin
        ra1 <= bus.read_addr;
        ra2 <= ra1;
        q_r <= ref_word(ra2);
    end
    assign bus.ram_q = q_r;

    // Downstream ready: 0 = stalled, 1 = always ready, other = random.
    always @(posedge clk) begin
        #1;
        if (ready_mode == 0)      bus.m_ready = 1'b0;
        else if (ready_mode == 1) bus.m_ready = 1'b1;
        else                      bus.m_ready = 1'($urandom_range(0, 1));
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: occupancy bound, head-of-stream against scoreboard, pops.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.busy && run_len != '0) begin
                check("occupancy_le_8",
                      64'((int'(c_AW'(bus.read_addr - run_base)) + 1 - delivered) <= 8), 64'd1);
            end
            if (bus.m_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_word", 64'(bus.m_data), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    mon_e = sb[0];
                    check("stream_data", bus.m_data, mon_e.d);
                    check("stream_last", 64'(bus.m_last), 64'(mon_e.l));
                    if (bus.m_ready) begin
                        void'(sb.pop_front());
                        delivered++;
                    end
                end
            end
        end
    end

    task automatic start_run(input logic [c_AW-1:0] b, input logic [c_AW-1:0] len);
        exp_t e;
        @(posedge clk); #1;
        bus.start     = 1'b1;
        bus.base_addr = b;
        bus.length    = len;
        t0        = cyc;
        run_base  = b;
        run_len   = len;
        delivered = 0;
        for (int i = 0; i < int'(len); i++) begin
            e.d = ref_word(b + c_AW'(i));
            e.l = (i == int'(len) - 1);
            sb.push_back(e);
        end
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic observe(input int max_cyc, input bit stop_on_done);
        int rel;
        first_v = -1; last_rel = -1; done_rel = -1; done_cnt = 0; busy_cnt = 0;
        for (int k = 0; k < max_cyc; k++) begin
            @(negedge clk);
            rel = cyc - t0;
            if (rel >= 0 && rel < 16) ra_log[rel] = bus.read_addr;
            if (bus.busy) busy_cnt++;
            if (bus.m_valid && first_v < 0) first_v = rel;
            if (bus.m_valid && bus.m_last && bus.m_ready) last_rel = rel;
            if (bus.done) begin
                done_cnt++;
                if (done_rel < 0) done_rel = rel;
                if (stop_on_done) break;
            end
        end
    endtask

    task automatic finish_run(input string name);
        check({name, "_done_seen"}, 64'(done_cnt), 64'd1);
        check({name, "_all_words"}, 64'(sb.size()), 64'd0);
        sb.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start     = 1'b0;
        bus.base_addr = '0;
        bus.length    = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy",      64'(bus.busy),      64'd0);
        check("rst_done",      64'(bus.done),      64'd0);
        check("rst_m_valid",   64'(bus.m_valid),   64'd0);
        check("rst_m_last",    64'(bus.m_last),    64'd0);
        check("rst_read_addr", 64'(bus.read_addr), 64'd0);
        check("rst_m_data",    bus.m_data,         64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Basic run with timing.
        ready_mode = 1;
        start_run(20'h00100, 20'd4);
        observe(30, 1'b1);
        check("basic_first_valid_cycle", 64'(first_v),  64'd5);
        check("basic_last_cycle",        64'(last_rel), 64'd8);
        check("basic_done_cycle",        64'(done_rel), 64'd9);
        check("basic_busy_cycles",       64'(busy_cnt), 64'd8);
        finish_run("basic");

        // Address wrap past all-ones.
        start_run(20'hFFFFE, 20'd4);
        observe(30, 1'b1);
        check("wrap_addr_c1", 64'(ra_log[1]), 64'h0FFFFE);
        check("wrap_addr_c2", 64'(ra_log[2]), 64'h0FFFFF);
        check("wrap_addr_c3", 64'(ra_log[3]), 64'h000000);
        check("wrap_addr_c4", 64'(ra_log[4]), 64'h000001);
        finish_run("wrap");

        // Empty run.
        start_run(20'h00040, 20'd0);
        observe(8, 1'b0);
        check("zero_done_cycle",  64'(done_rel), 64'd2);
        check("zero_no_valid",    64'(first_v),  64'hFFFF_FFFF_FFFF_FFFF);
        check("zero_busy_cycles", 64'(busy_cnt), 64'd1);
        finish_run("zero");

        // Random backpressure with a start pulse ignored mid-run.
        ready_mode = 2;
        start_run(20'h02000, 20'd16);
        fork
            observe(300, 1'b1);
            begin
                repeat (5) @(posedge clk); #1;
                bus.start     = 1'b1;
                bus.base_addr = 20'h77777;
                bus.length    = 20'd3;
                @(posedge clk); #1;
                bus.start = 1'b0;
            end
        join
        finish_run("backpressure");

        // Stall from the start: issue stops at eight words.
        ready_mode = 0;
        start_run(20'h03000, 20'd20);
        repeat (40) @(negedge clk);
        check("stall_read_addr", 64'(bus.read_addr), 64'h003007);
        check("stall_valid",     64'(bus.m_valid),   64'd1);
        ready_mode = 1;
        observe(200, 1'b1);
        finish_run("stall");

        // Reset mid-run.
        start_run(20'h04000, 20'd32);
        repeat (9) @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        run_len = '0;
        @(negedge clk);
        check("midrst_busy",      64'(bus.busy),      64'd0);
        check("midrst_done",      64'(bus.done),      64'd0);
        check("midrst_m_valid",   64'(bus.m_valid),   64'd0);
        check("midrst_m_last",    64'(bus.m_last),    64'd0);
        check("midrst_read_addr", 64'(bus.read_addr), 64'd0);
        check("midrst_m_data",    bus.m_data,         64'd0);
        observe(10, 1'b0);
        check("midrst_no_done", 64'(done_cnt), 64'd0);
        start_run(20'h00000, 20'd2);
        observe(40, 1'b1);
        check("midrst_fresh_words", 64'(delivered), 64'd2);
        finish_run("midrst_fresh");

        // Randomized runs.
        for (int r = 0; r < 6; r++) begin
            ready_mode = 2;
            start_run(c_AW'($urandom), c_AW'($urandom_range(1, 24)));
            observe(400, 1'b1);
            finish_run("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
